spart_rx: RTL and testbench

Serial receiver half of the SPART; the counterpart of the existing transmit path. It deserialises 8N1 frames (start bit, 8 data bits LSB first, stop bit) from the rxd line, timed by the same divisor_buffer baud count the transmitter uses. It presents each received byte in a holding register with a data-available flag, plus framing and overrun status, to the SPART bus interface.

---
 rtl/spart_rx.sv | 176 +++++++++++++++++
 tb/tb_spart_rx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_rx.sv
// SPART receive path: deserialises 8N1 frames from rxd using the shared baud
// divisor, holding the last byte with data-available, framing and overrun flags.
module spart_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic [15:0] divisor_buffer,
    input  logic        rd_ack,
    output logic [7:0]  rx_data,
    output logic        rda,
    output logic        framing_err,
    output logic        overrun,
    output logic        rx_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [15:0]            r_div;
    logic [15:0]            r_cnt;
    logic [2:0]             r_bitcnt;
    logic [7:0]             r_shift;
    logic [7:0]             r_rx_data;
    logic                   r_rda;
    logic                   r_framing_err;
    logic                   r_overrun;

    logic                   w_rxd_s;
    logic                   w_fall;
    logic                   w_tick;
    logic                   w_latch_div;
    logic                   w_cnt_load;
    logic [15:0]            w_cnt_val;
    logic                   w_shift_en;
    logic                   w_bit_clr;
    logic                   w_deliver;

    assign w_rxd_s = r_sync[SYNC_STAGES-1];
    assign w_fall  = r_prev & ~w_rxd_s;
    assign w_tick  = (r_cnt == '0);

    // Metastability synchroniser and previous-sample flop for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
            r_prev <= w_rxd_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath control; start-detect load uses the live divisor
    // because the latched copy only updates on that same edge
    always_comb begin
        w_state_next = r_state;
        w_latch_div  = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_val    = r_div;
        w_shift_en   = 1'b0;
        w_bit_clr    = 1'b0;
        w_deliver    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_latch_div  = 1'b1;
                    w_cnt_load   = 1'b1;
                    w_cnt_val    = divisor_buffer >> 1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (!w_rxd_s) begin
                        w_cnt_load   = 1'b1;
                        w_bit_clr    = 1'b1;
                        w_state_next = S_DATA;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_en = 1'b1;
                    w_cnt_load = 1'b1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_deliver    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Baud counter, divisor latch, bit counter and shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div    <= '0;
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
        end else begin
            if (w_latch_div) begin
                r_div <= divisor_buffer;
            end
            if (w_cnt_load) begin
                r_cnt <= w_cnt_val;
            end else if (!w_tick) begin
                r_cnt <= r_cnt - 16'd1;
            end
            if (w_bit_clr) begin
                r_bitcnt <= '0;
            end else if (w_shift_en) begin
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_shift_en) begin
                r_shift <= {w_rxd_s, r_shift[7:1]};
            end
        end
    end

    // Holding register and status flags; delivery takes priority over rd_ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_data     <= '0;
            r_rda         <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else if (w_deliver) begin
            r_rx_data     <= r_shift;
            r_rda         <= 1'b1;
            r_framing_err <= ~w_rxd_s;
            r_overrun     <= r_rda & ~rd_ack;
        end else if (rd_ack && r_rda) begin
            r_rda         <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end
    end

    assign rx_data     = r_rx_data;
    assign rda         = r_rda;
    assign framing_err = r_framing_err;
    assign overrun     = r_overrun;
    assign rx_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: directed and random 8N1 frames against a
// byte-level model of the holding register and status flags.
module tb_spart_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rxd = 1'b1;
    logic [15:0] divisor_buffer = 16'd15;
    logic        rd_ack = 1'b0;
    logic [7:0]  rx_data;
    logic        rda;
    logic        framing_err;
    logic        overrun;
    logic        rx_busy;

    spart_rx #(.SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .rxd            (rxd),
        .divisor_buffer (divisor_buffer),
        .rd_ack         (rd_ack),
        .rx_data        (rx_data),
        .rda            (rda),
        .framing_err    (framing_err),
        .overrun        (overrun),
        .rx_busy        (rx_busy)
    );

    always #5 clk = ~clk;

    // Free-running cycle count and rda rising-edge timestamp
    int   cyc = 0;
    int   rise_cyc = -1;
    logic prev_rda = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        prev_rda <= rda;
        if (rda && !prev_rda) rise_cyc <= cyc;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int start_cyc = 0;

    // Reference model of the bus-visible receiver state
    logic [7:0] e_data = 8'h00;
    logic       e_rda = 1'b0;
    logic       e_fe  = 1'b0;
    logic       e_ov  = 1'b0;

    function automatic int exp_latency(input int d);
        return 2 + (d >> 1) + 1 + 9 * (d + 1) + 1;
    endfunction

    task automatic model_deliver(input logic [7:0] b, input logic stop_v, input logic ack_same);
        e_ov   = e_rda && !ack_same;
        e_rda  = 1'b1;
        e_data = b;
        e_fe   = !stop_v;
    endtask

    task automatic model_ack();
        if (e_rda) begin
            e_rda = 1'b0;
            e_fe  = 1'b0;
            e_ov  = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic exp_busy);
        chk({tag, ".rx_data"}, {24'h0, rx_data}, {24'h0, e_data});
        chk({tag, ".rda"}, {31'h0, rda}, {31'h0, e_rda});
        chk({tag, ".framing_err"}, {31'h0, framing_err}, {31'h0, e_fe});
        chk({tag, ".overrun"}, {31'h0, overrun}, {31'h0, e_ov});
        chk({tag, ".rx_busy"}, {31'h0, rx_busy}, {31'h0, exp_busy});
    endtask

    // Drives one frame, starting and ending on a falling clock edge; the
    // divisor input is scrambled mid-frame since only the latched copy matters
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int d);
        divisor_buffer = d[15:0];
        rxd = 1'b0;
        start_cyc = cyc;
        repeat (d + 1) @(negedge clk);
        divisor_buffer = 16'($urandom_range(4, 65535));
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (d + 1) @(negedge clk);
        end
        rxd = stop_v;
        repeat (d + 1) @(negedge clk);
        divisor_buffer = d[15:0];
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        model_ack();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int d;
        logic [7:0] b;
        logic stop_v;
        logic check_lat;

        // Reset state while held and after release
        repeat (3) @(negedge clk);
        check_out("reset_held", 1'b0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_out("reset_rel", 1'b0);

        // 0xA5 at div=15: latency, contents
        send_frame(8'hA5, 1'b1, 15);
        model_deliver(8'hA5, 1'b1, 1'b0);
        chk("a5.latency", rise_cyc - start_cyc, 155);
        check_out("a5", 1'b0);

        // Ack clears rda next cycle while 0x3C follows back-to-back
        fork
            send_frame(8'h3C, 1'b1, 15);
            begin
                pulse_ack();
                chk("ack.rda", {31'h0, rda}, {31'h0, e_rda});
            end
        join
        model_deliver(8'h3C, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check_out("3c", 1'b0);

        // Two unread frames produce overrun; one ack clears all flags
        pulse_ack();
        send_frame(8'h11, 1'b1, 15);
        model_deliver(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 15);
        model_deliver(8'h22, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check_out("overrun", 1'b0);
        pulse_ack();
        check_out("overrun_ack", 1'b0);

        // Framing error: stop low, line stays low and must not restart
        send_frame(8'h55, 1'b0, 15);
        model_deliver(8'h55, 1'b0, 1'b0);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_busy) bc++;
        end
        chk("fe.no_restart", bc, 0);
        check_out("fe", 1'b0);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        pulse_ack();

        // 3-clock glitch is rejected at the start-bit sample
        bc = 0;
        rxd = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_busy) bc++;
            if (i == 2) rxd = 1'b1;
        end
        chk("glitch.busy_cycles", bc, (15 >> 1) + 1);
        check_out("glitch", 1'b0);

        // Random bytes, divisors, stop bits and acks
        for (int k = 0; k < 8; k++) begin
            d      = int'($urandom_range(4, 40));
            b      = 8'($urandom);
            stop_v = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) pulse_ack();
            check_lat = !e_rda;
            send_frame(b, stop_v, d);
            repeat (4) @(negedge clk);
            rxd = 1'b1;
            repeat (4) @(negedge clk);
            model_deliver(b, stop_v, 1'b0);
            if (check_lat) chk("rand.latency", rise_cyc - start_cyc, exp_latency(d));
            check_out("rand", 1'b0);
        end

        // Ensure flags are set, then reset during data bit 4
        send_frame(8'h6E, 1'b0, 15);
        model_deliver(8'h6E, 1'b0, 1'b0);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        fork
            send_frame(8'h9A, 1'b1, 15);
            begin
                repeat (90) @(negedge clk);
                rst = 1'b0;
                #1;
                e_data = 8'h00; e_rda = 1'b0; e_fe = 1'b0; e_ov = 1'b0;
                check_out("midreset", 1'b0);
            end
        join
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // 0xC3 after reset with rd_ack in the delivery cycle
        fork
            send_frame(8'hC3, 1'b1, 15);
            begin
                repeat (154) @(negedge clk);
                rd_ack = 1'b1;
                @(negedge clk);
                rd_ack = 1'b0;
            end
        join
        model_deliver(8'hC3, 1'b1, 1'b1);
        chk("c3.latency", rise_cyc - start_cyc, 155);
        check_out("c3", 1'b0);

        // Coincident ack while a byte is unread: delivery wins, no overrun
        fork
            send_frame(8'h0F, 1'b1, 15);
            begin
                repeat (154) @(negedge clk);
                rd_ack = 1'b1;
                @(negedge clk);
                rd_ack = 1'b0;
            end
        join
        model_deliver(8'h0F, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check_out("0f_ack_same", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
